axi4_burst_master: RTL
======================

Name: axi4_burst_master

Overview:
- Single-outstanding AXI4 burst master. Sits directly upstream of the memory-mapped AXI4 slave and drives its AW/W/B/AR/R channels.
- Converts a simple command stream (read/write, address, length, size) into one AXI4 INCR burst.
- Writes: streams data in from a write-data port. Reads: streams data out on a read-data port.
- Reports one completion status per command.

Parameters:
DATA_WIDTH, 32, width of WDATA/RDATA and the data streams
ADDR_WIDTH, 16, width of AWADDR/ARADDR/cmd_addr
TIMEOUT_CYCLES, 256, max idle cycles waiting on any AXI handshake before abort (>=2)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
cmd_valid/cmd_ready  in/out  1/1  command handshake
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  byte start address
cmd_len  in  8  beats minus one (AXLEN)
cmd_size  in  3  bytes per beat = 2^size (AXSIZE)
wd_valid/wd_ready/wd_data  in/out/in  1/1/DATA_WIDTH  write-data stream
rd_valid/rd_ready  out/in  1/1  read-data stream handshake
rd_data/rd_resp/rd_last  out  DATA_WIDTH/2/1  read beat payload
done_valid  out  1  one-cycle completion pulse
done_write/done_resp  out  1/2  completed command type and status
AWADDR/AWLEN/AWSIZE/AWVALID  out  ADDR_WIDTH/8/3/1  write address channel
AWREADY  in  1
WDATA/WVALID/WLAST  out  DATA_WIDTH/1/1; WREADY in 1  write data channel
BRESP/BVALID  in  2/1; BREADY out 1  write response channel
ARADDR/ARLEN/ARSIZE/ARVALID  out  ADDR_WIDTH/8/3/1; ARREADY in 1  read address channel
RDATA/RRESP/RLAST/RVALID  in  DATA_WIDTH/2/1/1; RREADY out 1  read data channel

Behaviour:
- Reset:
  - AWVALID=ARVALID=BREADY=0; AWADDR/ARADDR/AWLEN/ARLEN/AWSIZE/ARSIZE=0.
  - done_valid=0, done_resp=0, done_write=0.
  - beat counter=0, timeout counter=0, state=IDLE.
  - Reset mid-burst abandons the burst immediately; no completion is reported.
- States: IDLE, AW, W, B, AR, R.
- IDLE:
  - cmd_ready=1 (combinational from state).
  - On cmd_valid&&cmd_ready: latch addr/len/size, clear beat counter and worst-resp register.
  - Next cycle is AW with AWVALID=1 if cmd_write, else AR with ARVALID=1.
- AW:
  - AWVALID and AW fields held stable until AWREADY.
  - On handshake: AWVALID<=0, go to W.
- W (combinational pass-through):
  - WVALID=wd_valid, wd_ready=WREADY, WDATA=wd_data.
  - WLAST=(beat==len).
  - Each W handshake increments beat. Handshake with WLAST moves to B with BREADY<=1.
  - Outside W: WVALID=0, wd_ready=0.
- B:
  - On BVALID&&BREADY: BREADY<=0, done_valid<=1 for one cycle, done_write=1, done_resp=BRESP, go to IDLE.
- AR:
  - ARVALID and AR fields held stable until ARREADY.
  - On handshake: ARVALID<=0, go to R.
- R (combinational pass-through):
  - rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_resp=RRESP.
  - Each R handshake increments beat and updates worst-resp (max of codes).
  - A beat terminates the burst if any of these holds: RLAST=1, RRESP!=2'b00, or beat==len.
  - rd_last=1 on the terminating beat.
  - On termination: done_valid pulse, done_write=0, go to IDLE.
  - done_resp=worst-resp. If RLAST arrived with beat<len and RRESP=OKAY, done_resp=2'b10.
- done_valid has no backpressure. A new command is accepted no earlier than the cycle after done_valid.
- Timeout:
  - Counter clears on every AXI handshake and on state entry; increments each cycle in AW/W/B/AR/R.
  - At TIMEOUT_CYCLES-1: all valids/readies<=0, done_valid pulse with done_resp=2'b11, go to IDLE.
- Arithmetic:
  - Beat counter is 9 bits so len=255 gives 256 beats without wrap.
  - No address increment inside the master; address handling is the slave's job.
- 4KB boundary crossing is not checked; the master forwards the command unmodified and reports the slave's response.

Decomposition:
- Shared package axi4_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_TIMEOUT=2'b11.
  - master state enum.
  - burst-command struct (write, addr, len, size).
- One sub-module: axi4_timeout_ctr (clear, enable, expired output, parameter TIMEOUT_CYCLES).

Test Plan:
- Write addr=0x0010, len=3, size=2, data 0xA0..0xA3, slave OKAY -> AWLEN=3, four W beats, WLAST only on 4th, done_write=1, done_resp=00.
- Read addr=0x0010, len=3, rd_ready always 1 -> four rd beats 0xA0..0xA3, rd_last on 4th, done_resp=00.
- Read addr=0x2000 (beyond 1024 words) -> single beat RRESP=10 without RLAST terminates, rd_last=1, done_resp=10.
- wd_valid toggling 1-0-1 during write, and rd_ready stalled 5 cycles mid read -> no beat lost or duplicated, AWVALID/ARVALID stable until READY.
- Slave never asserts BVALID, TIMEOUT_CYCLES=16 -> done_resp=11 16 cycles after last W handshake, BREADY=0, cmd_ready=1 next cycle.
- ARESETn low during W beat 2 of len=7 -> all valids 0 asynchronously, no done_valid, next command accepted normally.

Source files
------------

// File: rtl/axi4_burst_master_pkg.sv
// Shared definitions for the AXI4 burst master: response codes, FSM state
// encodings, the latched burst-command record and a response-merge helper.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  typedef logic [2:0] mst_state_t;

  localparam mst_state_t ST_IDLE = 3'd0;
  localparam mst_state_t ST_AW   = 3'd1;
  localparam mst_state_t ST_W    = 3'd2;
  localparam mst_state_t ST_B    = 3'd3;
  localparam mst_state_t ST_AR   = 3'd4;
  localparam mst_state_t ST_R    = 3'd5;

  // The address is kept in its own register because its width is a
  // parameter of the master and cannot be sized inside the package.
  typedef struct packed {
    logic       write;
    logic [7:0] len;
    logic [2:0] size;
  } burst_cmd_t;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// AXI4 AW/W/B/AR/R channel bundle between the burst master and a memory slave.
interface axi4_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WLAST;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, input AWREADY,
    output WDATA, WVALID, WLAST, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARVALID, input ARREADY,
    input RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWLEN, AWSIZE, AWVALID, output AWREADY,
    input WDATA, WVALID, WLAST, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARLEN, ARSIZE, ARVALID, output ARREADY,
    output RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_burst_master_timeout_ctr.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1.
module axi4_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // A clear in the same cycle as expiry wins, so a late handshake is honoured.
  assign expired_o = enable_i && !clear_i && (cnt_q == LAST_CNT);

  // Idle-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i || expired_o) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end
endmodule

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one command in, one burst on the
// bus, one completion pulse out. W and R data are passed through combinationally.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_last,
  output logic                  done_valid,
  output logic                  done_write,
  output logic [1:0]            done_resp,
  axi4_burst_master_if.master   axi
);
  mst_state_t            state_q, state_d;
  burst_cmd_t            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            beat_q, beat_d;
  logic [1:0]            worst_q, worst_d;
  logic                  awvalid_q, awvalid_d, arvalid_q, arvalid_d, bready_q, bready_d;
  logic                  done_valid_q, done_valid_d, done_write_q, done_write_d;
  logic [1:0]            done_resp_q, done_resp_d;

  logic in_w_s, in_r_s, last_beat_s, r_term_s, early_last_s;
  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, expired_s;
  logic [1:0] r_worst_s;

  assign in_w_s       = (state_q == ST_W);
  assign in_r_s       = (state_q == ST_R);
  assign last_beat_s  = (beat_q == {1'b0, cmd_q.len});
  assign aw_hs_s      = awvalid_q && axi.AWREADY;
  assign w_hs_s       = in_w_s && wd_valid && axi.WREADY;
  assign b_hs_s       = bready_q && axi.BVALID;
  assign ar_hs_s      = arvalid_q && axi.ARREADY;
  assign r_hs_s       = in_r_s && axi.RVALID && rd_ready;
  assign r_term_s     = axi.RLAST || (axi.RRESP != RESP_OKAY) || last_beat_s;
  // Slave closed the burst short without flagging an error itself.
  assign early_last_s = axi.RLAST && (beat_q < {1'b0, cmd_q.len}) && (axi.RRESP == RESP_OKAY);
  assign r_worst_s    = resp_max(worst_q, axi.RRESP);

  axi4_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .clear_i   ((state_q == ST_IDLE) || aw_hs_s || w_hs_s || b_hs_s || ar_hs_s || r_hs_s),
    .enable_i  (state_q != ST_IDLE),
    .expired_o (expired_s)
  );

  assign cmd_ready   = (state_q == ST_IDLE) && !done_valid_q;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = cmd_q.len;
  assign axi.AWSIZE  = cmd_q.size;
  assign axi.AWVALID = awvalid_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = cmd_q.len;
  assign axi.ARSIZE  = cmd_q.size;
  assign axi.ARVALID = arvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.WVALID  = in_w_s && wd_valid;
  assign axi.WDATA   = wd_data;
  assign axi.WLAST   = in_w_s && last_beat_s;
  assign wd_ready    = in_w_s && axi.WREADY;
  assign rd_valid    = in_r_s && axi.RVALID;
  assign axi.RREADY  = in_r_s && rd_ready;
  assign rd_data     = axi.RDATA;
  assign rd_resp     = axi.RRESP;
  assign rd_last     = in_r_s && r_term_s;
  assign done_valid  = done_valid_q;
  assign done_write  = done_write_q;
  assign done_resp   = done_resp_q;

  // Next-state and channel-control logic
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    worst_d      = worst_q;
    awvalid_d    = awvalid_q;
    arvalid_d    = arvalid_q;
    bready_d     = bready_q;
    done_valid_d = 1'b0;
    done_write_d = done_write_q;
    done_resp_d  = done_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d     = '{write: cmd_write, len: cmd_len, size: cmd_size};
          addr_d    = cmd_addr;
          beat_d    = 9'd0;
          worst_d   = RESP_OKAY;
          awvalid_d = cmd_write;
          arvalid_d = !cmd_write;
          state_d   = cmd_write ? ST_AW : ST_AR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AW: begin
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
          state_d   = ST_W;
        end else begin
          state_d = ST_AW;
        end
      end
      ST_W: begin
        if (w_hs_s) begin
          beat_d = beat_q + 9'd1;
          if (last_beat_s) begin
            bready_d = 1'b1;
            state_d  = ST_B;
          end else begin
            state_d = ST_W;
          end
        end else begin
          state_d = ST_W;
        end
      end
      ST_B: begin
        if (b_hs_s) begin
          bready_d     = 1'b0;
          done_valid_d = 1'b1;
          done_write_d = 1'b1;
          done_resp_d  = axi.BRESP;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_B;
        end
      end
      ST_AR: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          state_d   = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (r_hs_s) begin
          beat_d  = beat_q + 9'd1;
          worst_d = r_worst_s;
          if (r_term_s) begin
            done_valid_d = 1'b1;
            done_write_d = 1'b0;
            done_resp_d  = early_last_s ? RESP_SLVERR : r_worst_s;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_R;
          end
        end else begin
          state_d = ST_R;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (expired_s) begin
      awvalid_d    = 1'b0;
      arvalid_d    = 1'b0;
      bready_d     = 1'b0;
      done_valid_d = 1'b1;
      done_write_d = cmd_q.write;
      done_resp_d  = RESP_TIMEOUT;
      state_d      = ST_IDLE;
    end else begin
      done_resp_d = done_resp_d;
    end
  end

  // State and output registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      beat_q       <= 9'd0;
      worst_q      <= RESP_OKAY;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_write_q <= 1'b0;
      done_resp_q  <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      worst_q      <= worst_d;
      awvalid_q    <= awvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      done_valid_q <= done_valid_d;
      done_write_q <= done_write_d;
      done_resp_q  <= done_resp_d;
    end
  end
endmodule
